// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states,
// default latencies and a small operand helper used by the datapath.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself, which
    // is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic is_long_op(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// Anything that is not a valid long op, including divide by zero, passes the current HI/LO through.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_t     op_i,
    input  logic [31:0] v1_i,
    input  logic [31:0] v2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] pend_hi_o,
    output logic [31:0] pend_lo_o
);

    logic        is_signed_s;
    logic        den_zero_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [31:0] div_a_s;
    logic [31:0] div_b_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Single shared multiplier and divider; signed ops are handled by sign
    // extension (multiply) or magnitude divide plus sign fix-up (divide).
    always_comb begin
        is_signed_s = (op_i == MDU_MULT) || (op_i == MDU_DIV);
        den_zero_s  = (v2_i == 32'd0);

        mul_a_s = is_signed_s ? {{32{v1_i[31]}}, v1_i} : {32'd0, v1_i};
        mul_b_s = is_signed_s ? {{32{v2_i[31]}}, v2_i} : {32'd0, v2_i};
        prod_s  = mul_a_s * mul_b_s;

        div_a_s = is_signed_s ? mag32(v1_i) : v1_i;
        if (den_zero_s) begin
            div_b_s = 32'd1;
        end else begin
            div_b_s = is_signed_s ? mag32(v2_i) : v2_i;
        end
        q_mag_s = div_a_s / div_b_s;
        r_mag_s = div_a_s % div_b_s;

        if (is_signed_s && (v1_i[31] ^ v2_i[31])) begin
            quot_s = 32'd0 - q_mag_s;
        end else begin
            quot_s = q_mag_s;
        end
        if (is_signed_s && v1_i[31]) begin
            rem_s = 32'd0 - r_mag_s;
        end else begin
            rem_s = r_mag_s;
        end
    end

    // Result select.
    always_comb begin
        pend_hi_o = hi_i;
        pend_lo_o = lo_i;
        case (op_i)
            MDU_MULT, MDU_MULTU: begin
                pend_hi_o = prod_s[63:32];
                pend_lo_o = prod_s[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                if (den_zero_s) begin
                    pend_hi_o = hi_i;
                    pend_lo_o = lo_i;
                end else begin
                    pend_hi_o = rem_s;
                    pend_lo_o = quot_s;
                end
            end
            default: begin
                pend_hi_o = hi_i;
                pend_lo_o = lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Results are computed at accept, held in pending registers, and committed after a fixed latency.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;

    mdu_op_t          op_s;
    logic             accept_s;
    logic             commit_s;
    logic [31:0]      arith_hi_s;
    logic [31:0]      arith_lo_s;

    assign op_s     = mdu_op_t'(op);
    assign accept_s = (state_q == ST_IDLE) && start && is_long_op(op_s);
    // A counter at or below one also commits, so a corrupted count cannot stall the pipe.
    assign commit_s = (state_q == ST_BUSY) && (cnt_q <= CNT_W'(1));

    mdu_arith u_arith (
        .op_i      (op_s),
        .v1_i      (v1),
        .v2_i      (v2),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .pend_hi_o (arith_hi_s),
        .pend_lo_o (arith_lo_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (commit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: counter, pending results and HI/LO next values.
    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_d     = is_div_op(op_s) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    pend_hi_d = arith_hi_s;
                    pend_lo_d = arith_lo_s;
                end else if (start && (op_s == MDU_MTHI)) begin
                    hi_d = v1;
                end else if (start && (op_s == MDU_MTLO)) begin
                    lo_d = v1;
                end else begin
                    cnt_d = CNT_W'(0);
                end
            end
            ST_BUSY: begin
                if (commit_s) begin
                    cnt_d = CNT_W'(0);
                    hi_d  = pend_hi_q;
                    lo_d  = pend_lo_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d = CNT_W'(0);
            end
        endcase
        busy_d = (state_d == ST_BUSY);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= CNT_W'(0);
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the five-stage MIPS pipeline, sitting in EX next to the single-cycle ALU. It owns the HI/LO register pair and executes mult/multu/div/divu with fixed latencies. It raises `busy` so the hazard unit can stall later HI/LO-touching instructions. It also services mthi/mtlo writes and provides HI/LO read values for mfhi/mflo.

## Interface
Parameters:
- MUL_CYCLES, 5, cycles from accept to HI/LO commit for mult/multu (≥1)
- DIV_CYCLES, 10, cycles from accept to HI/LO commit for div/divu (≥1)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  op valid this cycle (EX stage holds an MDU instruction)
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- v1  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- v2  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in flight; high from accept edge until commit edge
- hi  output  32  architectural HI (mfhi source)
- lo  output  32  architectural LO (mflo source)

## Operation
- States: IDLE, BUSY. Reset: IDLE, busy=0, hi=0, lo=0, counter=0.
- Accept: in IDLE with start=1 and op in 1..4. Latch the computed result into pending registers, load the counter with MUL_CYCLES or DIV_CYCLES, and go to BUSY.
- BUSY: the counter decrements each edge. On the edge where it reaches 0, commit pending→hi/lo and return to IDLE.
- mult: {hi,lo} = signed v1 × signed v2, 64-bit. multu: the same, unsigned.
- div: lo = quotient truncated toward zero, hi = remainder with the dividend's sign. divu: unsigned.
- div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (div/divu with v2=0): the op is accepted and busy runs the full DIV_CYCLES. At commit, hi/lo keep their previous values.
- mthi/mtlo: in IDLE with start=1, write v1 to hi or lo on that edge. busy stays 0.
- Ignored inputs:
  - start while BUSY (any op) is ignored. The hazard unit must never issue it; the bench checks that hi/lo/busy are unaffected.
  - op 0 or 7 with start=1 is ignored.
- hi/lo always show committed state. Pending results are never visible before commit.

## Timing
- Accept at edge E0. busy=1 after E0. Commit at edge E0+N, where N = MUL_CYCLES or DIV_CYCLES. At that same edge busy falls and the new hi/lo appear.
- busy is high for exactly N cycles.
- Back-to-back: a new start in the first IDLE cycle after commit is accepted, so there are zero bubble cycles.
- mthi/mtlo: value visible on hi/lo the cycle after the edge.
- Reset mid-operation: rst_n low forces IDLE, busy=0, hi=lo=0 immediately, without waiting for a clock. The pending result is discarded.
- Reset and start simultaneous: reset wins.
- Outputs busy/hi/lo are registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mdu_pkg`:
  - op encoding enum `mdu_op_t` (MDU_NONE..MDU_MTLO)
  - state enum `mdu_state_t`
  - default latency constants MDU_MUL_CYCLES=5, MDU_DIV_CYCLES=10
- The decoder and hazard unit import the same package.
- Sub-module `mdu_arith`: pure combinational 64-bit result generator (op, v1, v2, hi, lo → pending_hi, pending_lo). The divide-by-zero hold is implemented there by passing hi/lo through.
- Top level `mdu` holds the FSM, counter, pending registers and HI/LO.

## Test plan
- Reset then mult v1=0xFFFFFFFE (−2), v2=3 → busy high exactly 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu v1=0xFFFFFFFF, v2=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001. hi/lo unchanged during busy.
- div v1=−7 (0xFFFFFFF9), v2=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu by zero after mthi 0x1234 and mtlo 0x5678 → busy 10 cycles, hi=0x1234, lo=0x5678 retained.
- Start mult, pulse start with mtlo mid-busy, then assert rst_n=0 at cycle 3 without a clock edge:
  - The mtlo is ignored.
  - busy=0 and hi=lo=0 immediately.
  - After reset release, mult 2×3 accepted next cycle → lo=6, hi=0 after 5 cycles.
